// File: rtl/fp16_result_collector.sv
// Collects byte-serial FP16 products (low byte first) into 16-bit words and
// queues them in a small FIFO with class-flag decode of the head word.
module fp16_result_collector #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     clr,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_is_nan,
  output logic                     out_is_inf,
  output logic                     out_is_zero,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} phase_e;

  phase_e          phase_q, phase_d;
  logic [7:0]      low_byte_q, low_byte_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic [15:0]     word;
  logic [4:0]      head_exp;
  logic [9:0]      head_man;

  // Next-state: clr flushes regardless of ena; otherwise everything holds unless ena.
  always_comb begin
    phase_d    = phase_q;
    low_byte_d = low_byte_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    pop        = 1'b0;
    word       = {in_byte, low_byte_q};

    if (clr) begin
      phase_d    = LOW;
      low_byte_d = 8'h00;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (ena) begin
      pop = out_valid && out_ready;
      if (in_valid) begin
        if (phase_q == LOW) begin
          low_byte_d = in_byte;
          phase_d    = HIGH;
        end else begin
          phase_d = LOW;
          // A full FIFO still accepts the word when the head leaves this cycle.
          if ((count_q < CW'(DEPTH)) || pop) begin
            push = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q    <= LOW;
      low_byte_q <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      low_byte_q <= low_byte_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign head_exp    = out_data[14:10];
  assign head_man    = out_data[9:0];
  assign out_is_nan  = out_valid && (head_exp == 5'h1F) && (head_man != 10'h000);
  assign out_is_inf  = out_valid && (head_exp == 5'h1F) && (head_man == 10'h000);
  assign out_is_zero = out_valid && (head_exp == 5'h00);
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/fp16_result_collector.md
FP16_RESULT_COLLECTOR -- requirements
Module: fp16_result_collector

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL provide clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL provide ena  input  1  global enable; when low, all state holds.
REQ-005 SHALL provide clr  input  1  synchronous flush of FIFO, byte phase and overflow flag.
REQ-006 SHALL provide in_byte  input  8  byte-serial FP16 product from the multiplier, low byte first.
REQ-007 SHALL provide in_valid  input  1  in_byte is valid this cycle.
REQ-008 SHALL provide out_data  output  16  FP16 word at FIFO head.
REQ-009 SHALL provide out_valid  output  1  FIFO non-empty.
REQ-010 SHALL provide out_ready  input  1  consumer accepts head word.
REQ-011 SHALL provide out_is_nan, out_is_inf, out_is_zero  output  1 each  class flags of out_data.
REQ-012 SHALL provide fifo_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL provide overflow  output  1  sticky; a word was dropped because the FIFO was full.

Function
REQ-014 SHALL implement a two-state byte FSM, LOW and HIGH; after reset it is in LOW.
REQ-015 In LOW with ena and in_valid high, SHALL latch in_byte as the low byte and move to HIGH.
REQ-016 In HIGH with ena and in_valid high, SHALL form word {in_byte, low_byte}, attempt a push, and return to LOW.
REQ-017 With in_valid low, SHALL hold FSM state and latched low byte indefinitely; there is no timeout.
REQ-018 Pop SHALL occur when ena, out_valid and out_ready are all high.
REQ-019 Push SHALL succeed when fifo_count < DEPTH, or when fifo_count == DEPTH and a pop occurs in the same cycle.
REQ-020 A failed push SHALL discard the word, set overflow, and leave FIFO contents and count unchanged.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 A pushed word SHALL appear at out_data with out_valid high on the cycle after the push edge when the FIFO was empty (1-cycle latency); there is no combinational in-to-out path.
REQ-024 out_data, out_valid and class flags SHALL be combinational from registered FIFO state only; out_data SHALL be 16'h0000 when empty.
REQ-025 Class flags SHALL decode exp=out_data[14:10], man=out_data[9:0]: nan = exp==31 && man!=0; inf = exp==31 && man==0; zero = exp==0. All three SHALL be 0 when empty.
REQ-026 Priority SHALL be rst_n > clr > normal operation; clr SHALL take effect regardless of ena.
REQ-027 clr SHALL empty the FIFO, force LOW, clear overflow and discard the latched low byte; in_valid and out_ready are ignored that cycle.
REQ-028 overflow SHALL clear only on reset or clr.
REQ-029 With ena low, SHALL perform no push, pop, FSM or flag update; outputs reflect held state.

Reset
REQ-030 With rst_n low at a clock edge, SHALL set FSM to LOW, pointers and fifo_count to 0, low byte to 8'h00 and overflow to 0. Outputs SHALL then be out_valid 0, out_data 16'h0000, all class flags 0, fifo_count 0 and overflow 0.
REQ-031 Reset asserted mid-word, i.e. in HIGH, SHALL discard the partial word; the first byte after release is treated as a low byte.

Verification
REQ-032 Bytes 8'h00, 8'h3C (1.0) with out_ready=0 -> next cycle out_valid=1, out_data=16'h3C00, fifo_count=1, all flags 0.
REQ-033 Words 7C00, 7E01, 0000 pushed, then popped with out_ready=1 -> heads in order: inf=1; then nan=1; then zero=1; then out_valid=0.
REQ-034 Fill DEPTH=4 words with out_ready=0, push a 5th -> overflow=1, count=4, 5th word absent. Then pop plus push in the same cycle at full -> count stays 4 and the new word is last in order.
REQ-035 Send a single byte 8'hAA, assert clr, send 8'h00, 8'h40 -> out_data=16'h4000 (not 16'h00AA); overflow=0.
REQ-036 Word in flight (FSM in HIGH), drop ena for 3 cycles while toggling in_valid/out_ready, then send high byte with ena=1 -> no state change while disabled; word completes correctly.
REQ-037 Assert rst_n=0 in HIGH with 2 words queued -> count 0, out_valid 0; next 2 bytes 8'h00, 8'hC0 -> out_data=16'hC000.
